load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 7, meaning data memory word-index width (128 words).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, pipeline presents a memory op.
REQ-005 SHALL have port req_ready, output, 1, unit accepts the op this cycle.
REQ-006 SHALL have port req_op, input, 4, operation code (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, extended load result, 0 for stores.
REQ-011 SHALL have port resp_err, output, 1, misaligned or illegal op, qualified by resp_valid.
REQ-012 SHALL have ports mem_addr (output, 32), mem_write_data (output, 32), mem_write (output, 1), mem_read (output, 1), mem_read_data (input, 32), driving a word-addressed data memory with combinational read and posedge write.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, MERGE_WR, RESP.
REQ-014 SHALL assert req_ready only in IDLE; req_valid & req_ready latches op/addr/wdata and moves to ACCESS.
REQ-015 SHALL drive mem_addr = zero-extended req_addr[MEM_AW+1:2] from the latched address; byte-address bits above MEM_AW+1 ignored.
REQ-016 SHALL use little-endian lanes: byte k = bits [8k+7:8k], halfword at addr[1].
REQ-017 Loads: ACCESS asserts mem_read, captures the extracted and extended lane (sign for LB/LH, zero for LBU/LHU, whole word for LW) into resp_rdata, then RESP.
REQ-018 SW: ACCESS asserts mem_write with latched wdata, then RESP.
REQ-019 SB/SH: ACCESS asserts mem_read and registers the read word with the target lane(s) replaced; MERGE_WR asserts mem_write with the merged word; then RESP.
REQ-020 RESP SHALL pulse resp_valid for exactly one cycle, then return to IDLE; req_ready rises in that same IDLE cycle.
REQ-021 Latency from accept edge T: loads and SW give resp_valid at T+2, SB/SH at T+3.
REQ-022 Illegal req_op SHALL go ACCESS->RESP with no memory strobe, resp_err=1, resp_rdata=0.
REQ-023 mem_read and mem_write SHALL never be high in the same cycle, and SHALL both be low outside ACCESS/MERGE_WR.
REQ-024 req_valid while not ready SHALL be ignored; the pipeline holds the request until ready.

Reset
REQ-025 rst SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0.
REQ-026 rst asserted in ACCESS or MERGE_WR SHALL abort the op with no write and no response.

Configuration
REQ-027 With LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL skip memory and respond with resp_err=1.
REQ-028 Without LSU_MISALIGN_TRAP_EN, offending low address bits SHALL be forced to zero (natural alignment), the access SHALL proceed, and resp_err SHALL reflect only illegal ops.

Structure
REQ-029 Package lsu_pkg SHALL hold the op encodings (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10), the FSM state type and the lane-width constants.
REQ-030 Combinational sub-module lsu_align SHALL perform lane extract/extend and lane merge; the FSM and registers stay in load_store_unit.

Verification
REQ-031 mem word 13 = 0x00000003; LW addr 0x34 -> resp_valid at T+2, rdata 0x00000003, err 0.
REQ-032 Word 2 = 0x11223344; SB addr 0x09 wdata 0xAA -> read then write, word 2 = 0x1122AA44, resp_valid at T+3.
REQ-033 Word 4 = 0x8000F0FF; LB 0x10 -> 0xFFFFFFFF; LBU 0x10 -> 0x000000FF; LH 0x12 -> 0xFFFF8000; LHU 0x12 -> 0x00008000.
REQ-034 With LSU_MISALIGN_TRAP_EN, SW addr 0x06 -> no mem_write, resp_err=1; without it, word 1 is written.
REQ-035 rst pulsed during MERGE_WR of SH -> target word unchanged, no resp_valid, req_ready=1 after reset.
REQ-036 Back-to-back SW then LW to the same address with req_valid held -> second accepted the cycle after the first resp, returns the stored value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM state type,
// lane widths and small op-classification helpers.
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WR,
        RESP
    } lsu_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return op_legal(op) && !op[3];
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] align_zero_mask(input logic [3:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'b01;
            OP_LW, OP_SW:         return 2'b11;
            default:              return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: little-endian extract with sign/zero
// extension for loads, and byte/halfword merge into a word for partial stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] mem_word,
    input  logic [HALF_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = mem_word[7:0];
            2'd1:    lane_b = mem_word[15:8];
            2'd2:    lane_b = mem_word[23:16];
            default: lane_b = mem_word[31:24];
        endcase
        lane_h = offset[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = '0;
        case (op)
            OP_LB:   load_data = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
            OP_LBU:  load_data = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
            OP_LH:   load_data = {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
            OP_LHU:  load_data = {{(WORD_W-HALF_W){1'b0}}, lane_h};
            OP_LW:   load_data = mem_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        if (op == OP_SB) begin
            case (offset)
                2'd0:    merged_word[7:0]   = wdata[7:0];
                2'd1:    merged_word[15:8]  = wdata[7:0];
                2'd2:    merged_word[23:16] = wdata[7:0];
                default: merged_word[31:24] = wdata[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (offset[1])
                merged_word[31:16] = wdata;
            else
                merged_word[15:0] = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time through IDLE/ACCESS/MERGE_WR/RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = 7
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_e        state;
    logic [3:0]        op_q;
    logic [1:0]        offset_q;
    logic [HALF_W-1:0] wdata_q;
    logic              err_q;

    logic [1:0]        zero_mask;
    logic              misaligned;
    logic              trap;
    logic              needs_read;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged_word;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    always_comb begin
        zero_mask  = align_zero_mask(req_op);
        misaligned = |(req_addr[1:0] & zero_mask);
        trap       = !op_legal(req_op) || (TRAP_EN && misaligned);
        needs_read = op_is_load(req_op) || (req_op == OP_SB) || (req_op == OP_SH);
    end

    lsu_align u_align (
        .op          (op_q),
        .offset      (offset_q),
        .mem_word    (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Strobes are registered on entry to ACCESS so the combinational memory
    // read is valid for the whole ACCESS cycle and captured at its end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            offset_q       <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ACCESS;
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        offset_q  <= req_addr[1:0] & ~zero_mask;
                        wdata_q   <= req_wdata[HALF_W-1:0];
                        err_q     <= trap;
                        mem_addr  <= 32'(req_addr[MEM_AW+1:2]);
                        mem_read  <= !trap && needs_read;
                        mem_write <= !trap && (req_op == OP_SW);
                        if (!trap && (req_op == OP_SW))
                            mem_write_data <= req_wdata;
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (err_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else if (op_is_load(op_q)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end else if (op_q == OP_SW) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        state          <= MERGE_WR;
                        mem_write_data <= merged_word;
                        mem_write      <= 1'b1;
                    end
                end
                MERGE_WR: begin
                    state      <= RESP;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 128-word memory model.
module tb_load_store_unit;

    localparam int MEM_AW = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic        poke_en;
    logic [MEM_AW-1:0] poke_addr;
    logic [31:0] poke_data;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    int resp_cnt = 0;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[MEM_AW-1:0]];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (mem_write)
            mem[mem_addr[MEM_AW-1:0]] <= mem_write_data;
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) overlap++;
        if (resp_valid) resp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = idx[MEM_AW-1:0]; poke_data = data;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Drives one request and reports latency (negedges after the accept edge
    // until resp_valid is seen), strobe counts and the first-cycle mem_addr.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [31:0] maddr);
        int guard;
        lat = 0; nrd = 0; nwr = 0; rdata = '0; err = 1'b0; maddr = '0;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) maddr = mem_addr;
            if (mem_read) nrd++;
            if (mem_write) nwr++;
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_write_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        poke(13, 32'h0000_0003);
        run_op(4'd2, 32'h34, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL lw_rdata: got %h expected 00000003", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (ma !== 32'd13) begin errors++; $display("FAIL lw_mem_addr: got %h expected 0000000d", ma); end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL lw_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", nrd, nwr); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lw_after_resp: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_sb;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        poke(2, 32'h1122_3344);
        run_op(4'd8, 32'h09, 32'h0000_00AA, rd, er, lat, nrd, nwr, ma);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        checks++; if (nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL sb_strobes: got rd=%0d wr=%0d expected rd=1 wr=1", nrd, nwr); end
        checks++; if (mem[2] !== 32'h1122_AA44) begin errors++; $display("FAIL sb_word: got %h expected 1122aa44", mem[2]); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp: got rdata=%h err=%b expected 0/0", rd, er); end
    endtask

    task automatic test_sh;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        poke(3, 32'hA5A5_A5A5);
        run_op(4'd9, 32'h0C, 32'hFFFF_BEEF, rd, er, lat, nrd, nwr, ma);
        checks++; if (mem[3] !== 32'hA5A5_BEEF) begin errors++; $display("FAIL sh_word: got %h expected a5a5beef", mem[3]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_loads;
        logic [3:0]  ops  [6] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd0, 4'd4};
        logic [31:0] adrs [6] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h13, 32'h11};
        logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000, 32'h0000_8000,
                                  32'hFFFF_FF80, 32'h0000_00F0};
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        poke(4, 32'h8000_F0FF);
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], adrs[i], 32'h0, rd, er, lat, nrd, nwr, ma);
            checks++;
            if (rd !== exps[i] || er !== 1'b0 || lat !== 2) begin
                errors++;
                $display("FAIL load_%0d: got rdata=%h err=%b lat=%0d expected %h/0/2", i, rd, er, lat, exps[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        logic [3:0] bad [2] = '{4'd3, 4'd15};
        for (int i = 0; i < 2; i++) begin
            run_op(bad[i], 32'h34, 32'h1234_5678, rd, er, lat, nrd, nwr, ma);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 2 || nrd !== 0 || nwr !== 0) begin
                errors++;
                $display("FAIL illegal_%0d: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d expected 1/0/2/0/0", i, er, rd, lat, nrd, nwr);
            end
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        poke(1, 32'h0);
        poke(4, 32'h8000_F0FF);
        run_op(4'd10, 32'h06, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr, ma);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || nwr !== 0) begin errors++; $display("FAIL sw_misalign: got err=%b wr=%0d expected 1/0", er, nwr); end
        checks++; if (mem[1] !== 32'h0) begin errors++; $display("FAIL sw_misalign_word: got %h expected 00000000", mem[1]); end
        run_op(4'd1, 32'h13, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || nrd !== 0) begin errors++; $display("FAIL lh_misalign: got err=%b rdata=%h rd=%0d expected 1/0/0", er, rd, nrd); end
        run_op(4'd2, 32'h37, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign: got err=%b rdata=%h expected 1/0", er, rd); end
`else
        checks++; if (er !== 1'b0 || nwr !== 1) begin errors++; $display("FAIL sw_misalign: got err=%b wr=%0d expected 0/1", er, nwr); end
        checks++; if (mem[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_misalign_word: got %h expected deadbeef", mem[1]); end
        run_op(4'd1, 32'h13, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (er !== 1'b0 || rd !== 32'hFFFF_8000) begin errors++; $display("FAIL lh_misalign: got err=%b rdata=%h expected 0/ffff8000", er, rd); end
        run_op(4'd2, 32'h37, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (er !== 1'b0 || rd !== 32'h3) begin errors++; $display("FAIL lw_misalign: got err=%b rdata=%h expected 0/00000003", er, rd); end
`endif
    endtask

    task automatic test_addr_wrap;
        logic [31:0] rd, ma; logic er; int lat, nrd, nwr;
        run_op(4'd2, 32'h0000_0234, 32'h0, rd, er, lat, nrd, nwr, ma);
        checks++; if (ma !== 32'd13 || rd !== 32'h3) begin errors++; $display("FAIL addr_wrap: got mem_addr=%h rdata=%h expected 0000000d/00000003", ma, rd); end
    endtask

    task automatic test_reset_abort;
        int base;
        poke(5, 32'h5566_7788);
        @(negedge clk);
        req_op = 4'd9; req_addr = 32'h16; req_wdata = 32'h0000_1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL abort_access_read: got %b expected 1", mem_read); end
        @(negedge clk);
        checks++; if (mem_write !== 1'b1 || mem_write_data !== 32'h1234_7788) begin errors++; $display("FAIL abort_merge: got wr=%b data=%h expected 1/12347788", mem_write, mem_write_data); end
        base = resp_cnt;
        rst = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_async_clear: got %b expected 0", mem_write); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (resp_cnt !== base) begin errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", resp_cnt - base); end
        checks++; if (mem[5] !== 32'h5566_7788) begin errors++; $display("FAIL abort_word: got %h expected 55667788", mem[5]); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int first, second;
        logic ready2, ready3;
        logic [31:0] rd;
        first = 0; second = 0; ready2 = 1'b1; ready3 = 1'b0; rd = '0;
        poke(16, 32'h0);
        @(negedge clk);
        req_op = 4'd10; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 4'd2; req_wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) ready2 = req_ready;
            if (k == 3) ready3 = req_ready;
            if (k == 4) req_valid = 1'b0;
            if (resp_valid) begin
                if (first == 0) first = k;
                else if (second == 0) begin second = k; rd = resp_rdata; end
            end
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL b2b_first_resp: got %0d expected 2", first); end
        checks++; if (ready2 !== 1'b0 || ready3 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b%b expected 01", ready2, ready3); end
        checks++; if (second !== 5) begin errors++; $display("FAIL b2b_second_resp: got %0d expected 5", second); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata: got %h expected cafef00d", rd); end
        checks++; if (mem[16] !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_word: got %h expected cafef00d", mem[16]); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sb;
        test_sh;
        test_loads;
        test_illegal;
        test_misalign;
        test_addr_wrap;
        test_reset_abort;
        test_back_to_back;
        checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
